// File: rtl/trace_buffer.sv
// Double-banked column store between the ray tracer and the VGA pixel path.
// The tracer fills the back bank; the display reads and classifies from the front bank.
module trace_buffer #(
  parameter int COLS        = 640,
  parameter int VIEW_HEIGHT = 480,
  parameter int HBITS       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [9:0]       wr_col,
  input  logic             wr_side,
  input  logic [HBITS-1:0] wr_height,
  input  logic             frame_start,
  input  logic [9:0]       rd_h,
  input  logic [9:0]       rd_v,
  output logic [HBITS-1:0] rd_height,
  output logic             rd_side,
  output logic [1:0]       px_class,
  output logic             px_blank,
  output logic             front_valid,
  output logic [7:0]       stale_count
);

  localparam int          EW       = HBITS + 1;
  localparam logic [9:0]  COLS_L   = 10'(COLS);
  localparam logic [9:0]  LAST_COL = 10'(COLS - 1);
  localparam logic [9:0]  VIEW_L   = 10'(VIEW_HEIGHT);
  localparam logic [10:0] HALF     = 11'(VIEW_HEIGHT / 2);

  logic [EW-1:0] bank0 [COLS];
  logic [EW-1:0] bank1 [COLS];

  logic             front_bank_q,  front_bank_d;
  logic             complete_q,    complete_d;
  logic             front_valid_q, front_valid_d;
  logic [7:0]       stale_count_q, stale_count_d;
  logic [HBITS-1:0] rd_height_q,   rd_height_d;
  logic             rd_side_q,     rd_side_d;
  logic [9:0]       rd_v_q,        rd_v_d;
  logic             rd_blank_q,    rd_blank_d;

  logic             wr_accept;
  logic             rd_in_range;
  logic [9:0]       rd_idx;
  logic [EW-1:0]    rd_word;
  logic [10:0]      h_ext;
  logic [10:0]      h_clamp;
  logic [10:0]      v_ext;
  logic [10:0]      wall_lo;
  logic [10:0]      wall_hi;
  logic [1:0]       px_class_s;

  assign wr_accept = wr_en && (wr_col < COLS_L);

  // Writes always target the pre-swap back bank, so a write coinciding with a swap is shown.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      if (front_bank_q) begin
        bank0[wr_col] <= {wr_side, wr_height};
      end else begin
        bank1[wr_col] <= {wr_side, wr_height};
      end
    end
  end

  // Bank swap, completion tracking and stale-frame counting.
  always_comb begin
    front_bank_d  = front_bank_q;
    complete_d    = complete_q;
    front_valid_d = front_valid_q;
    stale_count_d = stale_count_q;
    if (frame_start && complete_q) begin
      front_bank_d  = ~front_bank_q;
      complete_d    = 1'b0;
      front_valid_d = 1'b1;
      stale_count_d = 8'd0;
    end else begin
      if (frame_start && (stale_count_q != 8'd255)) begin
        stale_count_d = stale_count_q + 8'd1;
      end else begin
        stale_count_d = stale_count_q;
      end
      if (wr_accept && (wr_col == LAST_COL)) begin
        complete_d = 1'b1;
      end else begin
        complete_d = complete_q;
      end
    end
  end

  // Read stage: the index is kept in range so the array access never goes out of bounds.
  always_comb begin
    rd_in_range = (rd_h < COLS_L);
    if (rd_in_range) begin
      rd_idx = rd_h;
    end else begin
      rd_idx = 10'd0;
    end
    if (front_bank_q) begin
      rd_word = bank1[rd_idx];
    end else begin
      rd_word = bank0[rd_idx];
    end
    if (rd_in_range) begin
      rd_height_d = rd_word[HBITS-1:0];
      rd_side_d   = rd_word[HBITS];
    end else begin
      rd_height_d = '0;
      rd_side_d   = 1'b0;
    end
    rd_v_d     = rd_v;
    rd_blank_d = !rd_in_range || (rd_v >= VIEW_L);
  end

  // State and stage-1 registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      front_bank_q  <= 1'b0;
      complete_q    <= 1'b0;
      front_valid_q <= 1'b0;
      stale_count_q <= 8'd0;
      rd_height_q   <= '0;
      rd_side_q     <= 1'b0;
      rd_v_q        <= 10'd0;
      rd_blank_q    <= 1'b1;
    end else begin
      front_bank_q  <= front_bank_d;
      complete_q    <= complete_d;
      front_valid_q <= front_valid_d;
      stale_count_q <= stale_count_d;
      rd_height_q   <= rd_height_d;
      rd_side_q     <= rd_side_d;
      rd_v_q        <= rd_v_d;
      rd_blank_q    <= rd_blank_d;
    end
  end

  // Pixel classification; the clamp keeps HALF - h_clamp from underflowing.
  always_comb begin
    h_ext = 11'(rd_height_q);
    if (!front_valid_q) begin
      h_clamp = 11'd0;
    end else if (h_ext > HALF) begin
      h_clamp = HALF;
    end else begin
      h_clamp = h_ext;
    end
    v_ext   = {1'b0, rd_v_q};
    wall_lo = HALF - h_clamp;
    wall_hi = HALF + h_clamp;
    if ((v_ext >= wall_lo) && (v_ext < wall_hi)) begin
      px_class_s = {1'b1, rd_side_q};
    end else if (v_ext < wall_lo) begin
      px_class_s = 2'd0;
    end else begin
      px_class_s = 2'd1;
    end
  end

  assign rd_height   = rd_height_q;
  assign rd_side     = rd_side_q;
  assign px_class    = px_class_s;
  assign px_blank    = rd_blank_q;
  assign front_valid = front_valid_q;
  assign stale_count = stale_count_q;

endmodule

// File: tb/tb_trace_buffer.sv
// Scoreboard bench for trace_buffer: directed reads push expectations, a monitor
// pops and compares one cycle later when the registered read result appears.
module tb_trace_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [9:0] wr_col;
  logic       wr_side;
  logic [7:0] wr_height;
  logic       frame_start;
  logic [9:0] rd_h;
  logic [9:0] rd_v;
  logic [7:0] rd_height;
  logic       rd_side;
  logic [1:0] px_class;
  logic       px_blank;
  logic       front_valid;
  logic [7:0] stale_count;

  always #5 clk = ~clk;

  trace_buffer #(.COLS(640), .VIEW_HEIGHT(480), .HBITS(8)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_col(wr_col), .wr_side(wr_side),
    .wr_height(wr_height), .frame_start(frame_start), .rd_h(rd_h), .rd_v(rd_v),
    .rd_height(rd_height), .rd_side(rd_side), .px_class(px_class), .px_blank(px_blank),
    .front_valid(front_valid), .stale_count(stale_count)
  );

  typedef struct {
    int h;
    int s;
    int c;
    int b;
    int fv;
    int st;
    bit dchk;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   item   = 0;
  logic chk_issue = 1'b0;
  logic chk_valid = 1'b0;

  always @(posedge clk) chk_valid <= chk_issue;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL item%0d %s: got %0d expected %0d", item, name, act, expv);
    end
  endtask

  // Monitor: compare the registered read result against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (chk_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL item%0d scoreboard: got output with no expectation queued", item);
      end else begin
        e = exp_q.pop_front();
        if (e.dchk) begin
          check("rd_height", int'(rd_height), e.h);
          check("rd_side", int'(rd_side), e.s);
        end
        check("px_class", int'(px_class), e.c);
        check("px_blank", int'(px_blank), e.b);
        check("front_valid", int'(front_valid), e.fv);
        check("stale_count", int'(stale_count), e.st);
      end
      item++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    wr_en       = 1'b0;
    frame_start = 1'b0;
    chk_issue   = 1'b0;
  endtask

  task automatic rd(input int h, input int v, input int eh, input int es, input int ec,
                    input int eb, input int efv, input int est, input bit dchk);
    exp_t e;
    rd_h = 10'(h);
    rd_v = 10'(v);
    e.h = eh; e.s = es; e.c = ec; e.b = eb; e.fv = efv; e.st = est; e.dchk = dchk;
    exp_q.push_back(e);
    chk_issue = 1'b1;
    step();
  endtask

  task automatic wr(input int col, input int side, input int height);
    wr_en     = 1'b1;
    wr_col    = 10'(col);
    wr_side   = 1'(side);
    wr_height = 8'(height);
  endtask

  // Trace pattern: height = col % 241, side = col[0], with one optional override column.
  task automatic write_frame(input int first, input int last, input int sc, input int sh, input int ss);
    for (int c = first; c <= last; c++) begin
      if (c == sc) wr(c, ss, sh);
      else         wr(c, c % 2, c % 241);
      step();
    end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_col = 10'd0; wr_side = 1'b0; wr_height = 8'd0;
    frame_start = 1'b0; rd_h = 10'd0; rd_v = 10'd0;

    // Reset state
    step();
    rd(0, 0, 0, 0, 0, 1, 0, 0, 1'b1);
    reset = 1'b0;

    // Incomplete trace: no swap, stale counts, walls hidden
    write_frame(0, 638, -1, 0, 0);
    frame_start = 1'b1;
    rd(5, 300, 0, 0, 1, 0, 0, 1, 1'b0);
    rd(5, 100, 0, 0, 0, 0, 0, 1, 1'b0);
    rd(640, 100, 0, 0, 0, 1, 0, 1, 1'b1);
    rd(10, 480, 0, 0, 1, 1, 0, 1, 1'b0);

    // Finish the trace and swap
    write_frame(639, 639, -1, 0, 0);
    frame_start = 1'b1;
    step();
    rd(100, 240, 100, 0, 2, 0, 1, 0, 1'b1);
    rd(101, 200, 101, 1, 3, 0, 1, 0, 1'b1);
    rd(101, 100, 101, 1, 0, 0, 1, 0, 1'b1);
    rd(0, 239, 0, 0, 0, 0, 1, 0, 1'b1);
    rd(0, 240, 0, 0, 1, 0, 1, 0, 1'b1);
    rd(639, 479, 157, 1, 1, 0, 1, 0, 1'b1);

    // Wall edges for height 40
    rd(40, 199, 40, 0, 0, 0, 1, 0, 1'b1);
    rd(40, 200, 40, 0, 2, 0, 1, 0, 1'b1);
    rd(40, 279, 40, 0, 2, 0, 1, 0, 1'b1);
    rd(40, 280, 40, 0, 1, 0, 1, 0, 1'b1);

    // Second frame with an over-tall column; read at the swap edge sees the old bank
    write_frame(0, 639, 300, 250, 0);
    frame_start = 1'b1;
    rd(300, 0, 59, 0, 0, 0, 1, 0, 1'b1);
    rd(300, 0, 250, 0, 2, 0, 1, 0, 1'b1);
    rd(300, 479, 250, 0, 2, 0, 1, 0, 1'b1);
    rd(300, 480, 250, 0, 1, 1, 1, 0, 1'b1);

    // Out-of-range write is dropped; last-column write racing frame_start
    write_frame(0, 638, -1, 0, 0);
    wr(700, 1, 99);
    step();
    frame_start = 1'b1;
    rd(639, 240, 157, 1, 3, 0, 1, 1, 1'b1);
    wr(639, 1, 77);
    frame_start = 1'b1;
    rd(639, 240, 157, 1, 3, 0, 1, 2, 1'b1);
    frame_start = 1'b1;
    rd(639, 240, 157, 1, 3, 0, 1, 0, 1'b1);
    rd(639, 240, 77, 1, 3, 0, 1, 0, 1'b1);
    rd(639, 162, 77, 1, 0, 0, 1, 0, 1'b1);
    rd(639, 163, 77, 1, 3, 0, 1, 0, 1'b1);
    rd(639, 316, 77, 1, 3, 0, 1, 0, 1'b1);
    rd(639, 317, 77, 1, 1, 0, 1, 0, 1'b1);

    // Reset mid-trace after the last column was written: trace discarded
    write_frame(0, 99, -1, 0, 0);
    write_frame(540, 639, -1, 0, 0);
    reset = 1'b1;
    step();
    rd(3, 20, 0, 0, 0, 1, 0, 0, 1'b1);
    reset = 1'b0;
    repeat (260) begin
      frame_start = 1'b1;
      step();
    end
    rd(100, 240, 100, 0, 1, 0, 0, 255, 1'b1);

    // Full rewrite restores the display
    write_frame(0, 639, 100, 60, 1);
    frame_start = 1'b1;
    step();
    rd(100, 240, 60, 1, 3, 0, 1, 0, 1'b1);
    rd(100, 179, 60, 1, 0, 0, 1, 0, 1'b1);
    rd(100, 300, 60, 1, 1, 0, 1, 0, 1'b1);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
